// File: rtl/sram_arbiter.sv
// Round-robin arbiter and strobe sequencer for a 256K x 16 asynchronous SRAM.
// Two command ports share one SRAM; every SRAM-side output comes straight from a flop.
module sram_arbiter #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic        io_mainClk,
  input  logic        io_asyncResetn,
  input  logic        io_p0_cmd_valid,
  output logic        io_p0_cmd_ready,
  input  logic        io_p0_cmd_write,
  input  logic [17:0] io_p0_cmd_addr,
  input  logic [15:0] io_p0_cmd_data,
  input  logic [1:0]  io_p0_cmd_mask,
  output logic        io_p0_rsp_valid,
  output logic [15:0] io_p0_rsp_data,
  input  logic        io_p1_cmd_valid,
  output logic        io_p1_cmd_ready,
  input  logic        io_p1_cmd_write,
  input  logic [17:0] io_p1_cmd_addr,
  input  logic [15:0] io_p1_cmd_data,
  input  logic [1:0]  io_p1_cmd_mask,
  output logic        io_p1_rsp_valid,
  output logic [15:0] io_p1_rsp_data,
  output logic [17:0] io_sram_addr,
  input  logic [15:0] io_sram_dat_read,
  output logic [15:0] io_sram_dat_write,
  output logic        io_sram_dat_writeEnable,
  output logic        io_sram_cs,
  output logic        io_sram_oe,
  output logic        io_sram_we,
  output logic        io_sram_ub,
  output logic        io_sram_lb
);

  if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
    $error("sram_arbiter: READ_WAIT must be in 1..15");
  end
  if (WRITE_WAIT < 1 || WRITE_WAIT > 15) begin : g_bad_write_wait
    $error("sram_arbiter: WRITE_WAIT must be in 1..15");
  end

  localparam logic [3:0] RD_CNT = 4'(READ_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WRITE_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        port_q, port_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  mask_q, mask_d;

  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] dat_write_q, dat_write_d;
  logic        dat_we_q, dat_we_d;
  logic        cs_q, cs_d, oe_q, oe_d, we_q, we_d, ub_q, ub_d, lb_q, lb_d;
  logic        rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
  logic [15:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;

  logic grant0, grant1, handshake, access_done;

  // On a tie the port that did not win last time gets the bus.
  assign grant0      = io_p0_cmd_valid & (~io_p1_cmd_valid | last_grant_q);
  assign grant1      = io_p1_cmd_valid & (~io_p0_cmd_valid | ~last_grant_q);
  assign handshake   = (state_q == IDLE) & (grant0 | grant1);
  assign access_done = (state_q == ACCESS) & (cnt_q == 4'd1);

  assign io_p0_cmd_ready = (state_q == IDLE) & grant0;
  assign io_p1_cmd_ready = (state_q == IDLE) & grant1;

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      port_q       <= 1'b0;
      addr_q       <= 18'd0;
      data_q       <= 16'd0;
      mask_q       <= 2'b00;
      sram_addr_q  <= 18'd0;
      dat_write_q  <= 16'd0;
      dat_we_q     <= 1'b0;
      cs_q         <= 1'b1;
      oe_q         <= 1'b1;
      we_q         <= 1'b1;
      ub_q         <= 1'b1;
      lb_q         <= 1'b1;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_data0_q  <= 16'd0;
      rsp_data1_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      sram_addr_q  <= sram_addr_d;
      dat_write_q  <= dat_write_d;
      dat_we_q     <= dat_we_d;
      cs_q         <= cs_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      ub_q         <= ub_d;
      lb_q         <= lb_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    port_d       = port_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d      = ACCESS;
          port_d       = grant1;
          last_grant_d = grant1;
          wr_d         = grant1 ? io_p1_cmd_write : io_p0_cmd_write;
          addr_d       = grant1 ? io_p1_cmd_addr  : io_p0_cmd_addr;
          data_d       = grant1 ? io_p1_cmd_data  : io_p0_cmd_data;
          mask_d       = grant1 ? io_p1_cmd_mask  : io_p0_cmd_mask;
          cnt_d        = wr_d ? WR_CNT : RD_CNT;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd1) begin
          state_d = wr_q ? RECOVER : IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from the next state so the strobes line up with it.
  always_comb begin
    sram_addr_d  = sram_addr_q;
    dat_write_d  = dat_write_q;
    dat_we_d     = 1'b0;
    cs_d         = 1'b1;
    oe_d         = 1'b1;
    we_d         = 1'b1;
    ub_d         = 1'b1;
    lb_d         = 1'b1;
    rsp_valid0_d = 1'b0;
    rsp_valid1_d = 1'b0;
    rsp_data0_d  = rsp_data0_q;
    rsp_data1_d  = rsp_data1_q;
    case (state_d)
      ACCESS: begin
        sram_addr_d = addr_d;
        cs_d        = 1'b0;
        if (wr_d) begin
          we_d        = 1'b0;
          dat_we_d    = 1'b1;
          dat_write_d = data_d;
          ub_d        = ~mask_d[1];
          lb_d        = ~mask_d[0];
        end else begin
          oe_d = 1'b0;
          ub_d = 1'b0;
          lb_d = 1'b0;
        end
      end
      RECOVER: begin
        cs_d     = 1'b0;
        dat_we_d = 1'b1;
        ub_d     = ub_q;
        lb_d     = lb_q;
      end
      default: ;
    endcase
    // Reads respond in the following IDLE cycle, writes in RECOVER; both leave ACCESS here.
    if (access_done) begin
      if (port_q) begin
        rsp_valid1_d = 1'b1;
        if (!wr_q) rsp_data1_d = io_sram_dat_read;
      end else begin
        rsp_valid0_d = 1'b1;
        if (!wr_q) rsp_data0_d = io_sram_dat_read;
      end
    end
  end

  assign io_sram_addr            = sram_addr_q;
  assign io_sram_dat_write       = dat_write_q;
  assign io_sram_dat_writeEnable = dat_we_q;
  assign io_sram_cs              = cs_q;
  assign io_sram_oe              = oe_q;
  assign io_sram_we              = we_q;
  assign io_sram_ub              = ub_q;
  assign io_sram_lb              = lb_q;
  assign io_p0_rsp_valid         = rsp_valid0_q;
  assign io_p0_rsp_data          = rsp_data0_q;
  assign io_p1_rsp_valid         = rsp_valid1_q;
  assign io_p1_rsp_data          = rsp_data1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed and random traffic against an SRAM model and a
// transaction-level reference (busy window, round-robin rule, expected memory).
module tb_sram_arbiter;
  localparam int RW = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic v0, r0, w0, rv0, v1, r1, w1, rv1;
  logic [17:0] a0, a1;
  logic [15:0] d0, d1, rd0, rd1;
  logic [1:0]  m0, m1;
  logic [17:0] sram_addr;
  logic [15:0] sram_rd, sram_wd;
  logic dwe, cs, oe, we, ub, lb;

  logic v_b, r_b, rv_b, r1_b, rv1_b, dwe_b, cs_b, oe_b, we_b, ub_b, lb_b;
  logic [17:0] a_b, sram_addr_b;
  logic [15:0] rd_b, rd1_b, sram_rd_b, sram_wd_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sram_arbiter #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .io_mainClk(clk), .io_asyncResetn(rst_n),
    .io_p0_cmd_valid(v0), .io_p0_cmd_ready(r0), .io_p0_cmd_write(w0),
    .io_p0_cmd_addr(a0), .io_p0_cmd_data(d0), .io_p0_cmd_mask(m0),
    .io_p0_rsp_valid(rv0), .io_p0_rsp_data(rd0),
    .io_p1_cmd_valid(v1), .io_p1_cmd_ready(r1), .io_p1_cmd_write(w1),
    .io_p1_cmd_addr(a1), .io_p1_cmd_data(d1), .io_p1_cmd_mask(m1),
    .io_p1_rsp_valid(rv1), .io_p1_rsp_data(rd1),
    .io_sram_addr(sram_addr), .io_sram_dat_read(sram_rd), .io_sram_dat_write(sram_wd),
    .io_sram_dat_writeEnable(dwe), .io_sram_cs(cs), .io_sram_oe(oe), .io_sram_we(we),
    .io_sram_ub(ub), .io_sram_lb(lb));

  sram_arbiter #(.READ_WAIT(1), .WRITE_WAIT(3)) dut_b (
    .io_mainClk(clk), .io_asyncResetn(rst_n),
    .io_p0_cmd_valid(v_b), .io_p0_cmd_ready(r_b), .io_p0_cmd_write(1'b0),
    .io_p0_cmd_addr(a_b), .io_p0_cmd_data(16'h0000), .io_p0_cmd_mask(2'b11),
    .io_p0_rsp_valid(rv_b), .io_p0_rsp_data(rd_b),
    .io_p1_cmd_valid(1'b0), .io_p1_cmd_ready(r1_b), .io_p1_cmd_write(1'b0),
    .io_p1_cmd_addr(18'h0), .io_p1_cmd_data(16'h0000), .io_p1_cmd_mask(2'b00),
    .io_p1_rsp_valid(rv1_b), .io_p1_rsp_data(rd1_b),
    .io_sram_addr(sram_addr_b), .io_sram_dat_read(sram_rd_b), .io_sram_dat_write(sram_wd_b),
    .io_sram_dat_writeEnable(dwe_b), .io_sram_cs(cs_b), .io_sram_oe(oe_b), .io_sram_we(we_b),
    .io_sram_ub(ub_b), .io_sram_lb(lb_b));

  assign sram_rd_b = (!cs_b && !oe_b) ? (sram_addr_b[15:0] ^ 16'hC3C3) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Power-on memory content, with two preset words for the directed tests.
  function automatic logic [15:0] pow_on(input logic [17:0] a);
    if (a == 18'h00123) return 16'hBEEF;
    if (a == 18'h3FFFF) return 16'h1234;
    return a[15:0] ^ 16'h5A3C;
  endfunction

  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] mem_get(input logic [17:0] a);
    return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : pow_on(a);
  endfunction
  function automatic logic [15:0] ref_get(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pow_on(a);
  endfunction

  always_comb begin
    sram_rd = 16'h0000;
    if (!cs && !oe) sram_rd = mem_get(sram_addr);
  end

  initial begin : sram_writer
    logic [15:0] cur;
    forever begin
      @(posedge clk);
      if (rst_n && !cs && !we) begin
        cur = mem_get(sram_addr);
        if (!lb) cur[7:0] = sram_wd[7:0];
        if (!ub) cur[15:8] = sram_wd[15:8];
        sram_mem[int'(sram_addr)] = cur;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: expected responses per port, arbiter busy window, round-robin state.
  typedef struct {int cyc; logic rd; logic [15:0] data;} exp_t;
  exp_t eq0[$], eq1[$];
  int busy_until = 0;
  logic lg = 1'b1;
  logic [15:0] last0 = 16'h0, last1 = 16'h0;
  int rsp_cnt0 = 0, rsp_cnt1 = 0;
  int grant_log[$];

  initial begin : monitor
    logic prev_oe, prev_dwe, er0, er1, p, hw;
    logic [17:0] ha;
    logic [15:0] hd, cur;
    logic [1:0]  hm;
    exp_t e;
    prev_oe = 1'b1;
    prev_dwe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eq0.delete(); eq1.delete();
        busy_until = 0; lg = 1'b1; last0 = 16'h0; last1 = 16'h0;
        prev_oe = 1'b1; prev_dwe = 1'b0;
        chk("rsp_during_reset", {30'd0, rv1, rv0}, 32'd0);
      end else begin
        if (rv0) begin
          if (eq0.size() == 0) chk("rsp0_unexpected", {31'd0, rv0}, 32'd0);
          else begin
            e = eq0.pop_front();
            chk("rsp0_cycle", cyc, e.cyc);
            if (e.rd) begin chk("rsp0_rdata", rd0, e.data); last0 = e.data; end
            else chk("rsp0_wdata_held", rd0, last0);
            rsp_cnt0++;
          end
        end else if (eq0.size() > 0 && eq0[0].cyc <= cyc) begin
          chk("rsp0_missing", cyc, eq0[0].cyc + 1);
          void'(eq0.pop_front());
        end
        if (rv1) begin
          if (eq1.size() == 0) chk("rsp1_unexpected", {31'd0, rv1}, 32'd0);
          else begin
            e = eq1.pop_front();
            chk("rsp1_cycle", cyc, e.cyc);
            if (e.rd) begin chk("rsp1_rdata", rd1, e.data); last1 = e.data; end
            else chk("rsp1_wdata_held", rd1, last1);
            rsp_cnt1++;
          end
        end else if (eq1.size() > 0 && eq1[0].cyc <= cyc) begin
          chk("rsp1_missing", cyc, eq1[0].cyc + 1);
          void'(eq1.pop_front());
        end
        if (rv0 || rv1) chk("rsp_both_ports", {31'd0, rv0 & rv1}, 32'd0);
        if (v0 || v1) begin
          er0 = 1'b0; er1 = 1'b0;
          if (cyc >= busy_until) begin
            er0 = v0 && (!v1 || lg);
            er1 = v1 && (!v0 || !lg);
          end
          chk("cmd_ready", {30'd0, r1, r0}, {30'd0, er1, er0});
        end
        if ((v0 && r0) || (v1 && r1)) begin
          p  = v1 && r1;
          hw = p ? w1 : w0;
          ha = p ? a1 : a0;
          hd = p ? d1 : d0;
          hm = p ? m1 : m0;
          lg = p;
          grant_log.push_back(int'(p));
          e.rd = !hw;
          if (hw) begin
            cur = ref_get(ha);
            if (hm[0]) cur[7:0] = hd[7:0];
            if (hm[1]) cur[15:8] = hd[15:8];
            ref_mem[int'(ha)] = cur;
            e.data = 16'h0;
            e.cyc = cyc + WW + 1;
            busy_until = cyc + WW + 2;
          end else begin
            e.data = ref_get(ha);
            e.cyc = cyc + RW + 1;
            busy_until = cyc + RW + 1;
          end
          if (p) eq1.push_back(e); else eq0.push_back(e);
        end
        if (!oe && prev_oe) chk("turnaround_dwe_before_oe", {31'd0, prev_dwe}, 32'd0);
        if (dwe) chk("contention_oe_high", {31'd0, oe}, 32'd1);
        prev_oe = oe;
        prev_dwe = dwe;
      end
    end
  end

  typedef struct packed {logic wr; logic [17:0] addr; logic [15:0] data; logic [1:0] mask;} cmd_t;
  cmd_t q0[$], q1[$];

  task automatic wait_hs(input int p);
    int n;
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (p == 0 ? (v0 && r0) : (v1 && r1)) break;
    end
    chk("handshake_wait", {31'd0, n < 64}, 32'd1);
  endtask

  task automatic run_streams(input int drop_pct, input int gap_pct);
    int n;
    logic acc0, acc1;
    cmd_t c;
    for (n = 0; n < 4000; n++) begin
      @(negedge clk);
      acc0 = v0 && r0;
      acc1 = v1 && r1;
      @(posedge clk); #1;
      if (acc0) v0 = 1'b0;
      else if (v0 && $urandom_range(99) < drop_pct) v0 = 1'b0;
      if (!v0 && q0.size() > 0 && $urandom_range(99) >= gap_pct) begin
        c = q0.pop_front(); v0 = 1'b1; w0 = c.wr; a0 = c.addr; d0 = c.data; m0 = c.mask;
      end
      if (acc1) v1 = 1'b0;
      else if (v1 && $urandom_range(99) < drop_pct) v1 = 1'b0;
      if (!v1 && q1.size() > 0 && $urandom_range(99) >= gap_pct) begin
        c = q1.pop_front(); v1 = 1'b1; w1 = c.wr; a1 = c.addr; d1 = c.data; m1 = c.mask;
      end
      if (!v0 && !v1 && q0.size() == 0 && q1.size() == 0) break;
    end
    chk("stream_budget", {31'd0, n < 4000}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int c0, c1;
    int hs[$], rs[$];
    logic [15:0] exp_b[$];
    logic [17:0] addrs_b[4];
    logic acc;
    int idx;
    v0 = 0; w0 = 0; a0 = 0; d0 = 0; m0 = 0;
    v1 = 0; w1 = 0; a1 = 0; d1 = 0; m1 = 0;
    v_b = 0; a_b = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {27'd0, cs, oe, we, ub, lb}, 32'h1F);
    chk("rst_dwe", {31'd0, dwe}, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dat_write", {16'd0, sram_wd}, 32'd0);
    chk("rst_rsp", {rv0, rv1, 14'd0, rd0 | rd1}, 32'd0);
    chk("rst_ready", {30'd0, r0, r1}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Port 0 read of the preset word
    v0 = 1; w0 = 0; a0 = 18'h00123; m0 = 2'b00;
    wait_hs(0);
    @(posedge clk); #1 v0 = 0;
    chk("rd_t1_cs_oe_ublb", {28'd0, cs, oe, ub, lb}, 32'h0);
    chk("rd_t1_addr", {14'd0, sram_addr}, 32'h00123);
    @(posedge clk); #1;
    chk("rd_t2_cs_oe", {30'd0, cs, oe}, 32'h0);
    @(posedge clk); #1;
    chk("rd_t3_rsp", {15'd0, rv0, rd0}, {15'd0, 1'b1, 16'hBEEF});
    chk("rd_t3_idle_strobes", {30'd0, cs, oe}, 32'h3);
    @(posedge clk); #1;
    chk("rd_t4_rsp_pulse", {31'd0, rv0}, 32'd0);

    // Port 1 lower-byte write to the top address
    v1 = 1; w1 = 1; a1 = 18'h3FFFF; d1 = 16'hA55A; m1 = 2'b01;
    wait_hs(1);
    @(posedge clk); #1 v1 = 0;
    for (int i = 1; i <= WW; i++) begin
      chk("wr_access_strobes", {26'd0, cs, we, oe, dwe, ub, lb}, 32'b001110);
      chk("wr_access_data", {sram_wd, 14'd0, sram_addr[17:16]}, {16'hA55A, 14'd0, 2'b11});
      @(posedge clk); #1;
    end
    chk("wr_recover_strobes", {26'd0, cs, we, oe, dwe, ub, lb}, 32'b011110);
    chk("wr_recover_hold", {sram_wd, sram_addr[15:0]}, {16'hA55A, 16'hFFFF});
    chk("wr_recover_rsp", {31'd0, rv1}, 32'd1);
    @(posedge clk); #1;
    chk("wr_idle_strobes", {28'd0, cs, we, oe, dwe}, 32'b1110);
    chk("wr_mem_bytes", {16'd0, mem_get(18'h3FFFF)}, 32'h125A);

    // Both ports stream four reads each: grants must alternate
    grant_log.delete();
    c0 = rsp_cnt0; c1 = rsp_cnt1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b0, 18'(i), 16'h0, 2'b11});
      q1.push_back({1'b0, 18'(8 + i), 16'h0, 2'b11});
    end
    run_streams(0, 0);
    chk("rr_grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) chk("rr_grant_order", grant_log[i], i % 2);
    chk("rr_rsp_count_p0", rsp_cnt0 - c0, 4);
    chk("rr_rsp_count_p1", rsp_cnt1 - c1, 4);

    // Write then read of the same word from one port
    q0.push_back({1'b1, 18'h00050, 16'(($urandom & 16'hFFFF) | 1), 2'b11});
    q0.push_back({1'b0, 18'h00050, 16'h0, 2'b00});
    c0 = rsp_cnt0;
    run_streams(0, 0);
    chk("wr_rd_rsp_count", rsp_cnt0 - c0, 2);

    // Reset during the first write ACCESS cycle
    v0 = 1; w0 = 1; a0 = 18'h00777; d0 = 16'h1111; m0 = 2'b11;
    wait_hs(0);
    @(posedge clk); #1 v0 = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_strobes", {29'd0, we, cs, dwe}, 32'b110);
    chk("mid_reset_rsp", {30'd0, rv0, rv1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    grant_log.delete();
    q0.push_back({1'b0, 18'h00010, 16'h0, 2'b00});
    q1.push_back({1'b0, 18'h00020, 16'h0, 2'b00});
    run_streams(0, 0);
    chk("post_reset_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("post_reset_first_grant", grant_log[0], 0);

    // Random mixed traffic with gaps and abandoned requests
    c0 = rsp_cnt0; c1 = rsp_cnt1;
    for (int i = 0; i < 30; i++) begin
      q0.push_back({1'($urandom), 18'($urandom_range(15)), 16'($urandom), 2'($urandom)});
      q1.push_back({1'($urandom), 18'($urandom_range(15)), 16'($urandom), 2'($urandom)});
    end
    run_streams(10, 30);
    chk("rand_pending_drained", eq0.size() + eq1.size(), 0);

    // READ_WAIT = 1 instance: back-to-back port 0 reads
    for (int i = 0; i < 4; i++) addrs_b[i] = 18'(100 + 7 * i);
    idx = 0;
    @(posedge clk); #1;
    v_b = 1; a_b = addrs_b[0];
    for (int n = 0; n < 40 && rs.size() < 4; n++) begin
      @(negedge clk);
      if (rv_b) begin
        rs.push_back(cyc);
        if (exp_b.size() > 0) chk("rw1_rdata", rd_b, exp_b.pop_front());
        else chk("rw1_rsp_unexpected", {31'd0, rv_b}, 32'd0);
      end
      acc = v_b && r_b;
      if (acc) begin
        hs.push_back(cyc);
        exp_b.push_back(a_b[15:0] ^ 16'hC3C3);
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) a_b = addrs_b[idx]; else v_b = 0;
      end
    end
    v_b = 0;
    chk("rw1_hs_count", hs.size(), 4);
    chk("rw1_rsp_count", rs.size(), 4);
    for (int i = 0; i < 4 && i < hs.size() && i < rs.size(); i++) chk("rw1_latency", rs[i] - hs[i], 2);
    for (int i = 1; i < hs.size(); i++) chk("rw1_issue_period", hs[i] - hs[i-1], 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
